mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage; sits between the EX/MEM register and WB_module.
//  Issues loads/stores on an SRAM-like data bus and stalls the pipeline until the bus responds.
//  Checks address alignment, then registers everything WB consumes (MEM/WB register).
//  Memdata_out is the raw aligned word; byte/half extraction is done in WB.
// PARAMETERS
//  WIDTH     32     datapath width
//  EXC_ADEL  4'd4   exception code, misaligned load
//  EXC_ADES  4'd5   exception code, misaligned store
// PORTS
//  clk           in   1      clock
//  rst           in   1      synchronous active-high reset
//  valid_in      in   1      EX/MEM holds a live instruction
//  flush         in   1      exception flush; kill M instruction
//  aluout_in     in   WIDTH  ALU result / effective address
//  wdata_in      in   32     store data (rt)
//  MemRead_in    in   1      load
//  MemWrite_in   in   1      store
//  mem_type_in   in   3      [1:0] 00 byte, 01 half, 10 word; [2] sign-extend
//  ctrl_in       in   -      MemtoReg, RegWrite, WritetoRFaddr[6:0], HILO_data[63:0], HI_LO_writeenable, PC[31:0], exception[3:0], is_ds
//  data_req      out  1      bus request
//  data_wr       out  1      1 = write
//  data_size     out  2      0 = byte, 1 = half, 2 = word
//  data_addr     out  32     byte address
//  data_wdata    out  32     lane-replicated store data
//  data_addr_ok  in   1      request accepted
//  data_data_ok  in   1      transfer done; rdata valid
//  data_rdata    in   32     read word
//  stall_out     out  1      freeze PC, IF/ID, ID/EX, EX/MEM
//  valid_out     out  1      MEM/WB holds a live instruction
//  aluout_out, Memdata_out(32), MemReadType_out(3), MemWrite_out, ctrl_out  out  registered to WB_module
// BEHAVIOUR
//  - FSM states: IDLE, ADDR, DATA. rst -> IDLE; every registered output is 0; kill_r = 0.
//  - Memory op: op = valid_in & (MemRead_in | MemWrite_in) & exception_in == 0 & aligned & !flush.
//  - Aligned rule: half needs addr[0] = 0; word needs addr[1:0] = 0.
//  - Misaligned access: no bus request is made.
//    - exception_out = EXC_ADEL (load) or EXC_ADES (store).
//    - MemWrite_out = 0.
//    - Completes in 1 cycle as a non-memory instruction.
//  - IDLE: if op, go to ADDR. stall_out = 1 in that cycle.
//  - ADDR: data_req = 1. addr/size/wr/wdata are held stable from the latched copy until data_addr_ok.
//    - data_addr_ok & data_data_ok in the same cycle: complete.
//    - data_addr_ok alone: go to DATA.
//  - DATA: data_req = 0; wait for data_data_ok, then complete.
//  - Complete cycle:
//    - stall_out = 0.
//    - Memdata_out <= data_rdata.
//    - MEM/WB captures the instruction; state -> IDLE.
//  - stall_out = (IDLE & op) | (ADDR | DATA) & !complete. Combinational.
//  - Non-memory instruction: passes to MEM/WB in 1 cycle; no stall.
//  - Load-to-WB latency = 2 + bus latency cycles.
//  - Store data lanes:
//    - byte: {4{wdata[7:0]}}
//    - half: {2{wdata[15:0]}}
//    - word: wdata unchanged.
//    - data_size = mem_type[1:0].
//  - flush while in ADDR or DATA:
//    - The bus transaction cannot be cancelled: req stays high until addr_ok, then data_ok is awaited.
//    - kill_r is set; on complete MEM/WB loads a bubble.
//    - stall_out keeps its normal value.
//  - flush in IDLE: no request; MEM/WB loads a bubble.
//  - Bubble: valid_out = 0, RegWrite_out = 0, MemWrite_out = 0, exception_out = 0.
//  - While stalled: MEM/WB holds its previous contents, but RegWrite_out and MemWrite_out are forced to 0 after the first cycle. This prevents duplicate WB writes.
//  - Pass-through fields: copied unchanged on capture, including the MemtoReg polarity.
//  - MemReadType_out = mem_type_in.
// TESTING
//  - lw 0x8000_0004, rdata 0xDEAD_BEEF, addr_ok after 1 cycle, data_ok after 2 more -> stall 4 cycles; Memdata_out = 0xDEADBEEF, RegWrite_out = 1.
//  - sb addr 0x..03, wdata 0x0000_00A5 -> data_wdata = 0xA5A5_A5A5, size = 0, data_wr = 1; MemWrite_out = 1.
//  - lh addr 0x..01 -> no data_req; exception_out = 4; stall_out never high.
//  - addr_ok and data_ok same cycle as req -> one stall cycle; correct Memdata_out.
//  - flush in DATA -> req is not reissued; wait for data_ok; valid_out = 0, RegWrite_out = 0.
//  - rst asserted in ADDR -> next cycle IDLE, data_req = 0, all outputs 0.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores on an SRAM-like bus, stalls until the bus
// responds, flags misaligned accesses and holds the MEM/WB register feeding WB_module.
module mem_access_stage #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [3:0]  EXC_ADEL = 4'd4,
  parameter logic [3:0]  EXC_ADES = 4'd5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             flush,
  input  logic [WIDTH-1:0] aluout_in,
  input  logic [31:0]      wdata_in,
  input  logic             MemRead_in,
  input  logic             MemWrite_in,
  input  logic [2:0]       mem_type_in,
  input  logic             MemtoReg_in,
  input  logic             RegWrite_in,
  input  logic [6:0]       WritetoRFaddr_in,
  input  logic [63:0]      HILO_data_in,
  input  logic             HI_LO_writeenable_in,
  input  logic [31:0]      PC_in,
  input  logic [3:0]       exception_in,
  input  logic             is_ds_in,
  output logic             data_req,
  output logic             data_wr,
  output logic [1:0]       data_size,
  output logic [31:0]      data_addr,
  output logic [31:0]      data_wdata,
  input  logic             data_addr_ok,
  input  logic             data_data_ok,
  input  logic [31:0]      data_rdata,
  output logic             stall_out,
  output logic             valid_out,
  output logic [WIDTH-1:0] aluout_out,
  output logic [31:0]      Memdata_out,
  output logic [2:0]       MemReadType_out,
  output logic             MemWrite_out,
  output logic             MemtoReg_out,
  output logic             RegWrite_out,
  output logic [6:0]       WritetoRFaddr_out,
  output logic [63:0]      HILO_data_out,
  output logic             HI_LO_writeenable_out,
  output logic [31:0]      PC_out,
  output logic [3:0]       exception_out,
  output logic             is_ds_out
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] aluout;
    logic [31:0]      memdata;
    logic [2:0]       mem_type;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic [6:0]       rf_addr;
    logic [63:0]      hilo;
    logic             hilo_we;
    logic [31:0]      pc;
    logic [3:0]       exception;
    logic             is_ds;
  } memwb_t;

  state_e      state_q;
  logic        kill_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        wr_q;
  memwb_t      memwb_q, memwb_d;

  logic        mem_access, aligned, misaligned, op, complete, capture, bubble;
  logic [31:0] lane_wdata;

  always_comb begin
    // NOTE: every signal gets a default first so no branch leaves it unassigned (no latch).
    aligned    = 1'b1;
    lane_wdata = wdata_in;
    case (mem_type_in[1:0])
      2'b00:   lane_wdata = {4{wdata_in[7:0]}};
      2'b01: begin
        aligned    = ~aluout_in[0];
        lane_wdata = {2{wdata_in[15:0]}};
      end
      default: aligned = (aluout_in[1:0] == 2'b00);
    endcase
  end

  assign mem_access = valid_in & (MemRead_in | MemWrite_in) & (exception_in == 4'd0);
  assign misaligned = mem_access & ~aligned;
  assign op         = mem_access & aligned & ~flush;
  assign complete   = ((state_q == ADDR) & data_addr_ok & data_data_ok)
                    | ((state_q == DATA) & data_data_ok);
  assign stall_out  = ((state_q == IDLE) & op) | ((state_q != IDLE) & ~complete);
  assign capture    = ~stall_out;
  // A flush that lands mid-transaction is remembered in kill_q until the bus finishes.
  assign bubble     = ~valid_in | flush | kill_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        IDLE: if (op) begin
          state_q <= ADDR;
          addr_q  <= aluout_in[31:0];
          wdata_q <= lane_wdata;
          size_q  <= mem_type_in[1:0];
          wr_q    <= MemWrite_in;
        end
        ADDR:    if (data_addr_ok) state_q <= data_data_ok ? IDLE : DATA;
        DATA:    if (data_data_ok) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (complete)                        kill_q <= 1'b0;
      else if ((state_q != IDLE) && flush) kill_q <= 1'b1;
    end
  end

  always_comb begin
    memwb_d = memwb_q;
    if (capture) begin
      memwb_d.valid      = ~bubble;
      memwb_d.aluout     = aluout_in;
      memwb_d.mem_type   = mem_type_in;
      memwb_d.mem_write  = ~bubble & ~misaligned & MemWrite_in;
      memwb_d.mem_to_reg = MemtoReg_in;
      memwb_d.reg_write  = ~bubble & RegWrite_in;
      memwb_d.rf_addr    = WritetoRFaddr_in;
      memwb_d.hilo       = HILO_data_in;
      memwb_d.hilo_we    = HI_LO_writeenable_in;
      memwb_d.pc         = PC_in;
      memwb_d.exception  = bubble     ? 4'd0 :
                           misaligned ? (MemRead_in ? EXC_ADEL : EXC_ADES) : exception_in;
      memwb_d.is_ds      = is_ds_in;
    end else begin
      // Held instruction must not write RF/memory a second time while the stage stalls.
      memwb_d.reg_write = 1'b0;
      memwb_d.mem_write = 1'b0;
    end
    if (complete) memwb_d.memdata = data_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) memwb_q <= '0;
    else     memwb_q <= memwb_d;
  end

  assign data_req   = (state_q == ADDR);
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;

  assign valid_out             = memwb_q.valid;
  assign aluout_out            = memwb_q.aluout;
  assign Memdata_out           = memwb_q.memdata;
  assign MemReadType_out       = memwb_q.mem_type;
  assign MemWrite_out          = memwb_q.mem_write;
  assign MemtoReg_out          = memwb_q.mem_to_reg;
  assign RegWrite_out          = memwb_q.reg_write;
  assign WritetoRFaddr_out     = memwb_q.rf_addr;
  assign HILO_data_out         = memwb_q.hilo;
  assign HI_LO_writeenable_out = memwb_q.hilo_we;
  assign PC_out                = memwb_q.pc;
  assign exception_out         = memwb_q.exception;
  assign is_ds_out             = memwb_q.is_ds;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases, then random instructions
// with a bus responder, all compared against a per-instruction reference model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst, valid_in, flush, MemRead_in, MemWrite_in, MemtoReg_in, RegWrite_in;
  logic        HI_LO_writeenable_in, is_ds_in, data_addr_ok, data_data_ok;
  logic [31:0] aluout_in, wdata_in, PC_in, data_rdata;
  logic [2:0]  mem_type_in;
  logic [6:0]  WritetoRFaddr_in;
  logic [63:0] HILO_data_in;
  logic [3:0]  exception_in;
  logic        data_req, data_wr, stall_out, valid_out, MemWrite_out, MemtoReg_out, RegWrite_out;
  logic        HI_LO_writeenable_out, is_ds_out;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, aluout_out, Memdata_out, PC_out;
  logic [2:0]  MemReadType_out;
  logic [6:0]  WritetoRFaddr_out;
  logic [63:0] HILO_data_out;
  logic [3:0]  exception_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush), .aluout_in(aluout_in),
    .wdata_in(wdata_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .mem_type_in(mem_type_in), .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
    .WritetoRFaddr_in(WritetoRFaddr_in), .HILO_data_in(HILO_data_in),
    .HI_LO_writeenable_in(HI_LO_writeenable_in), .PC_in(PC_in), .exception_in(exception_in),
    .is_ds_in(is_ds_in), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .stall_out(stall_out),
    .valid_out(valid_out), .aluout_out(aluout_out), .Memdata_out(Memdata_out),
    .MemReadType_out(MemReadType_out), .MemWrite_out(MemWrite_out),
    .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
    .WritetoRFaddr_out(WritetoRFaddr_out), .HILO_data_out(HILO_data_out),
    .HI_LO_writeenable_out(HI_LO_writeenable_out), .PC_out(PC_out),
    .exception_out(exception_out), .is_ds_out(is_ds_out)
  );

  typedef struct {
    logic        valid, rd, wr, mem_to_reg, reg_write, hilo_we, is_ds;
    logic [2:0]  mtype;
    logic [31:0] addr, wdata, pc;
    logic [6:0]  rf;
    logic [63:0] hilo;
    logic [3:0]  exc;
  } instr_t;

  typedef struct {
    logic        valid, mem_write, mem_to_reg, reg_write, hilo_we, is_ds;
    logic [31:0] aluout, pc;
    logic [2:0]  mtype;
    logic [6:0]  rf;
    logic [63:0] hilo;
    logic [3:0]  exception;
  } wb_t;

  wb_t         exp_wb;
  bit          memdata_chk;
  logic [31:0] exp_memdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic instr_t mk(input logic rd, input logic wr, input logic [2:0] mt,
                                input logic [31:0] addr, input logic [31:0] wdata);
    instr_t t;
    t.valid = 1'b1; t.rd = rd; t.wr = wr; t.mtype = mt; t.addr = addr; t.wdata = wdata;
    t.mem_to_reg = rd; t.reg_write = rd; t.rf = 7'd9; t.hilo = 64'h1234_5678_9abc_def0;
    t.hilo_we = 1'b0; t.pc = 32'hbfc0_0100; t.exc = 4'd0; t.is_ds = 1'b0;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    int kind;
    kind        = $urandom_range(0, 2);
    t.valid     = ($urandom_range(0, 9) != 0);
    t.rd        = (kind == 1);
    t.wr        = (kind == 2);
    t.mtype     = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
    t.addr      = $urandom;
    if ($urandom_range(0, 3) != 0) t.addr = t.addr & ~32'h3;
    t.wdata     = $urandom;
    t.mem_to_reg = 1'($urandom); t.reg_write = 1'($urandom); t.hilo_we = 1'($urandom);
    t.is_ds     = 1'($urandom);
    t.rf        = 7'($urandom);
    t.hilo      = {$urandom, $urandom};
    t.pc        = $urandom;
    t.exc       = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
    return t;
  endfunction

  task automatic drive(input instr_t t);
    valid_in = t.valid; MemRead_in = t.rd; MemWrite_in = t.wr; mem_type_in = t.mtype;
    aluout_in = t.addr; wdata_in = t.wdata; MemtoReg_in = t.mem_to_reg;
    RegWrite_in = t.reg_write; WritetoRFaddr_in = t.rf; HILO_data_in = t.hilo;
    HI_LO_writeenable_in = t.hilo_we; PC_in = t.pc; exception_in = t.exc; is_ds_in = t.is_ds;
  endtask

  task automatic idle_inputs();
    instr_t t;
    t = mk(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    t.valid = 1'b0; t.rf = 7'd0; t.hilo = 64'd0; t.pc = 32'd0;
    drive(t);
    flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
  endtask

  task automatic check_prev();
    check("valid_out", valid_out, exp_wb.valid);
    check("aluout_out", aluout_out, exp_wb.aluout);
    check("MemReadType_out", MemReadType_out, exp_wb.mtype);
    check("MemWrite_out", MemWrite_out, exp_wb.mem_write);
    check("MemtoReg_out", MemtoReg_out, exp_wb.mem_to_reg);
    check("RegWrite_out", RegWrite_out, exp_wb.reg_write);
    check("WritetoRFaddr_out", WritetoRFaddr_out, exp_wb.rf);
    check("HILO_data_out", HILO_data_out, exp_wb.hilo);
    check("HI_LO_we_out", HI_LO_writeenable_out, exp_wb.hilo_we);
    check("PC_out", PC_out, exp_wb.pc);
    check("exception_out", exception_out, exp_wb.exception);
    check("is_ds_out", is_ds_out, exp_wb.is_ds);
    if (memdata_chk) check("Memdata_out", Memdata_out, exp_memdata);
  endtask

  // Runs one instruction: a_dly request cycles without addr_ok, data_ok arriving d_dly
  // cycles after the addr_ok cycle, optional flush at cycle flush_cyc (-1 = none).
  task automatic run_instr(input instr_t in, input int a_dly, input int d_dly,
                           input int flush_cyc, input logic [31:0] rdata);
    int          nbytes, last;
    bit          memacc, aligned, is_op, misal, bubble, exp_req;
    logic [31:0] exp_lane;
    nbytes  = 1 << in.mtype[1:0];
    memacc  = in.valid && (in.rd || in.wr) && (in.exc == 4'd0);
    aligned = (in.addr % nbytes) == 0;
    is_op   = memacc && aligned && (flush_cyc != 0);
    misal   = memacc && !aligned;
    last    = is_op ? 1 + a_dly + d_dly : 0;
    bubble  = !in.valid || (flush_cyc >= 0 && flush_cyc <= last);
    if (nbytes == 1)      exp_lane = {24'd0, in.wdata[7:0]} * 32'h0101_0101;
    else if (nbytes == 2) exp_lane = {16'd0, in.wdata[15:0]} * 32'h0001_0001;
    else                  exp_lane = in.wdata;

    for (int cyc = 0; cyc <= last; cyc++) begin
      @(negedge clk);
      drive(in);
      flush        = (cyc == flush_cyc);
      data_addr_ok = is_op && (cyc == 1 + a_dly);
      data_data_ok = is_op && (cyc == 1 + a_dly + d_dly);
      data_rdata   = data_data_ok ? rdata : $urandom;
      #1;
      if (cyc == 0) check_prev();
      if (cyc == 1) begin
        check("held valid_out", valid_out, exp_wb.valid);
        check("held PC_out", PC_out, exp_wb.pc);
        check("held RegWrite_out", RegWrite_out, 1'b0);
        check("held MemWrite_out", MemWrite_out, 1'b0);
      end
      check("stall_out", stall_out, cyc < last);
      exp_req = is_op && (cyc >= 1) && (cyc <= 1 + a_dly);
      check("data_req", data_req, exp_req);
      if (exp_req) begin
        check("data_addr", data_addr, in.addr);
        check("data_wr", data_wr, in.wr);
        check("data_size", data_size, in.mtype[1:0]);
        check("data_wdata", data_wdata, exp_lane);
      end
    end

    exp_wb.valid      = !bubble;
    exp_wb.aluout     = in.addr;
    exp_wb.mtype      = in.mtype;
    exp_wb.mem_write  = !bubble && !misal && in.wr;
    exp_wb.mem_to_reg = in.mem_to_reg;
    exp_wb.reg_write  = !bubble && in.reg_write;
    exp_wb.rf         = in.rf;
    exp_wb.hilo       = in.hilo;
    exp_wb.hilo_we    = in.hilo_we;
    exp_wb.pc         = in.pc;
    exp_wb.exception  = bubble ? 4'd0 : misal ? (in.rd ? 4'd4 : 4'd5) : in.exc;
    exp_wb.is_ds      = in.is_ds;
    memdata_chk       = is_op;
    exp_memdata       = rdata;
  endtask

  task automatic clear_model();
    exp_wb = '{valid: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b0,
               hilo_we: 1'b0, is_ds: 1'b0, aluout: 32'd0, pc: 32'd0, mtype: 3'd0,
               rf: 7'd0, hilo: 64'd0, exception: 4'd0};
    memdata_chk = 1'b1;
    exp_memdata = 32'd0;
  endtask

  initial begin
    instr_t t;
    int     a, d, f;

    // Reset state
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    check("reset data_req", data_req, 1'b0);
    check("reset stall_out", stall_out, 1'b0);
    check("reset data_addr", data_addr, 32'd0);
    clear_model();
    check_prev();
    rst = 1'b0;

    // lw with addr_ok after 1 cycle, data_ok 2 cycles later: 4 stall cycles
    run_instr(mk(1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'd0), 1, 2, -1, 32'hDEAD_BEEF);
    // sb at byte 3: lane-replicated data
    run_instr(mk(1'b0, 1'b1, 3'b000, 32'h1000_0003, 32'h0000_00A5), 0, 0, -1, 32'd0);
    // misaligned lh: no request, ADEL
    run_instr(mk(1'b1, 1'b0, 3'b101, 32'h1000_0001, 32'd0), 0, 0, -1, 32'd0);
    // misaligned sw: no request, ADES
    run_instr(mk(1'b0, 1'b1, 3'b010, 32'h1000_0006, 32'h1234_5678), 0, 0, -1, 32'd0);
    // addr_ok and data_ok together: one stall cycle
    run_instr(mk(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0), 0, 0, -1, 32'hCAFE_F00D);
    // sh: half-lane replication
    run_instr(mk(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hFFFF_1234), 2, 1, -1, 32'd0);
    // flush while in DATA: bus finishes, MEM/WB gets a bubble
    run_instr(mk(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0), 0, 3, 2, 32'h5555_AAAA);
    // flush in IDLE on a memory op: no request, bubble
    run_instr(mk(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'd0), 0, 0, 0, 32'd0);
    run_instr(mk(1'b0, 1'b0, 3'b010, 32'h0000_0500, 32'd0), 0, 0, -1, 32'd0);

    // Reset asserted while in ADDR
    @(negedge clk);
    drive(mk(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'd0));
    flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    @(negedge clk);
    #1;
    check("pre-reset data_req", data_req, 1'b1);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    #1;
    check("rst in ADDR data_req", data_req, 1'b0);
    check("rst in ADDR stall_out", stall_out, 1'b0);
    check("rst in ADDR data_addr", data_addr, 32'd0);
    clear_model();
    check_prev();
    rst = 1'b0;

    // Random instructions with random bus latency and occasional flush
    for (int n = 0; n < 250; n++) begin
      t = rand_instr();
      a = $urandom_range(0, 3);
      d = $urandom_range(0, 3);
      f = ($urandom_range(0, 6) == 0) ? $urandom_range(0, 4) : -1;
      run_instr(t, a, d, f, $urandom);
    end
    // Trailing idle instruction checks the last MEM/WB capture
    t = mk(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    t.valid = 1'b0;
    run_instr(t, 0, 0, -1, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
